// File: rtl/clock_pkg.sv
// clock_pkg: mode encoding, field widths/limits and the wrap helper used by the clock setter
package clock_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} mode_t;
  localparam int H_W = 5;
  localparam int M_W = 6;
  localparam int S_W = 6;
  localparam logic [H_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [M_W-1:0] MIN_MAX = 6'd59;
  localparam logic [S_W-1:0] SEC_MAX = 6'd59;
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max, input logic down);
    return down ? (v == 6'd0 ? max : v - 6'd1) : (v == max ? 6'd0 : v + 6'd1);
  endfunction
endpackage

// File: rtl/press_timer.sv
// press_timer: saturating press-duration counter with registered half/3 s/5 s threshold levels
module press_timer #(
  parameter int CLK_HZ = 1000
) (
  input  logic clock,
  input  logic rst,
  input  logic cnt_run,
  output logic sec_half,
  output logic sec_3,
  output logic sec_5
);
  localparam int MAX = 5 * CLK_HZ;
  localparam int CNT_W = $clog2(MAX + 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt <= '0;
      sec_half <= 1'b0;
      sec_3 <= 1'b0;
      sec_5 <= 1'b0;
    end else begin
      cnt <= !cnt_run ? '0 : (cnt == CNT_W'(MAX) ? cnt : cnt + 1'b1);
      sec_half <= cnt >= CNT_W'(CLK_HZ / 2);
      sec_3 <= cnt >= CNT_W'(3 * CLK_HZ);
      sec_5 <= cnt >= CNT_W'(MAX);
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: click-driven set-mode FSM editing shadow h/m/s, with commit strobe and inactivity abort
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 1000,
  parameter int TIMEOUT_S = 10
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           cnt_run,
  input  logic           tick_1hz,
  input  logic           click_1,
  input  logic           click_2,
  input  logic           click_3,
  input  logic           click_3s,
  input  logic           click_5s,
  input  logic [H_W-1:0] cur_h,
  input  logic [M_W-1:0] cur_m,
  input  logic [S_W-1:0] cur_s,
  output logic           sec_half,
  output logic           sec_3,
  output logic           sec_5,
  output logic [1:0]     mode,
  output logic           run_en,
  output logic [H_W-1:0] edit_h,
  output logic [M_W-1:0] edit_m,
  output logic [S_W-1:0] edit_s,
  output logic           load
);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  mode_t mode_q, mode_n;
  logic [H_W-1:0] h_n;
  logic [M_W-1:0] m_n;
  logic [S_W-1:0] s_n;
  logic [TW-1:0] to_cnt, to_n;
  logic load_n, expire;
  press_timer #(.CLK_HZ(CLK_HZ)) u_press (
    .clock(clock), .rst(rst), .cnt_run(cnt_run),
    .sec_half(sec_half), .sec_3(sec_3), .sec_5(sec_5)
  );
  assign mode = mode_q;
  assign expire = to_cnt == TW'(TIMEOUT_S - 1);
  // Click chain in priority order; the timeout only advances when no click arrived this cycle
  always_comb begin
    mode_n = mode_q;
    h_n = edit_h;
    m_n = edit_m;
    s_n = edit_s;
    to_n = '0;
    load_n = 1'b0;
    if (mode_q == RUN) begin
      if (click_3s && !click_5s) begin
        mode_n = SET_H;
        h_n = cur_h;
        m_n = cur_m;
        s_n = cur_s;
      end
    end else if (click_5s) mode_n = RUN;
    else if (click_3s) begin
      mode_n = RUN;
      load_n = 1'b1;
    end else if (click_3) begin
      mode_n = mode_q == SET_H ? SET_M : mode_q == SET_M ? SET_S : RUN;
      load_n = mode_q == SET_S;
    end else if (click_1 || click_2) begin
      h_n = mode_q == SET_H ? H_W'(step_wrap({1'b0, edit_h}, {1'b0, HOUR_MAX}, click_2)) : edit_h;
      m_n = mode_q == SET_M ? step_wrap(edit_m, MIN_MAX, click_2) : edit_m;
      s_n = mode_q == SET_S ? step_wrap(edit_s, SEC_MAX, click_2) : edit_s;
    end else if (tick_1hz) begin
      mode_n = expire ? RUN : mode_q;
      to_n = expire ? '0 : to_cnt + 1'b1;
    end else to_n = to_cnt;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      mode_q <= RUN;
      run_en <= 1'b1;
      load <= 1'b0;
      edit_h <= '0;
      edit_m <= '0;
      edit_s <= '0;
      to_cnt <= '0;
    end else begin
      mode_q <= mode_n;
      run_en <= mode_n == RUN;
      load <= load_n;
      edit_h <= h_n;
      edit_m <= m_n;
      edit_s <= s_n;
      to_cnt <= to_n;
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed + random stimulus, expected outputs queued by a rule-level model and checked by a monitor
module tb_clock_set_ctrl;
  localparam int CLK_HZ = 10;
  localparam int TIMEOUT_S = 3;
  localparam bit [4:0] C1 = 5'b00001, C2 = 5'b00010, C3 = 5'b00100, C3S = 5'b01000, C5S = 5'b10000;
  logic clock = 1'b0, rst = 1'b1, cnt_run = 1'b0, tick_1hz = 1'b0;
  logic click_1 = 1'b0, click_2 = 1'b0, click_3 = 1'b0, click_3s = 1'b0, click_5s = 1'b0;
  logic [4:0] cur_h = '0;
  logic [5:0] cur_m = '0, cur_s = '0;
  logic sec_half, sec_3, sec_5, run_en, load;
  logic [1:0] mode;
  logic [4:0] edit_h;
  logic [5:0] edit_m, edit_s;
  clock_set_ctrl #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clock(clock), .rst(rst), .cnt_run(cnt_run), .tick_1hz(tick_1hz),
    .click_1(click_1), .click_2(click_2), .click_3(click_3), .click_3s(click_3s), .click_5s(click_5s),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .sec_half(sec_half), .sec_3(sec_3), .sec_5(sec_5),
    .mode(mode), .run_en(run_en), .edit_h(edit_h), .edit_m(edit_m), .edit_s(edit_s), .load(load)
  );
  always #5 clock = ~clock;
  typedef struct {int md; bit run; bit ld; int h; int m; int s; bit sh; bit s3; bit s5;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int md = 0, to = 0, pc = 0;
  int fld[1:3] = '{0, 0, 0};
  int lim[1:3] = '{24, 60, 60};
  bit ld = 0, sh = 0, s3 = 0, s5 = 0;
  bit run_req = 0;
  int nh = 0, nm = 0, ns = 0;
  task automatic chk(input string nm_s, input int a, input int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm_s, a, e);
  endtask
  // Model: mode 0 = RUN, 1..3 = editing field fld[mode] modulo lim[mode]
  task automatic step(input bit [4:0] c, input bit t, input bit r);
    @(negedge clock);
    {click_5s, click_3s, click_3, click_2, click_1} = c;
    tick_1hz = t;
    rst = r;
    cnt_run = run_req;
    cur_h = 5'(nh);
    cur_m = 6'(nm);
    cur_s = 6'(ns);
    ld = 0;
    if (r) begin
      md = 0; fld = '{0, 0, 0}; to = 0; pc = 0; sh = 0; s3 = 0; s5 = 0;
    end else begin
      sh = pc >= CLK_HZ / 2;
      s3 = pc >= 3 * CLK_HZ;
      s5 = pc >= 5 * CLK_HZ;
      pc = run_req ? (pc < 5 * CLK_HZ ? pc + 1 : pc) : 0;
      if (md == 0) begin
        if (c[3] && !c[4]) begin md = 1; fld = '{nh, nm, ns}; end
      end else if (c[4]) md = 0;
      else if (c[3]) begin md = 0; ld = 1; end
      else if (c[2]) begin ld = (md == 3); md = (md + 1) % 4; end
      else if (c[1]) fld[md] = (fld[md] + lim[md] - 1) % lim[md];
      else if (c[0]) fld[md] = (fld[md] + 1) % lim[md];
      else if (t) begin
        to++;
        if (to == TIMEOUT_S) md = 0;
      end
      if (c != 0 || md == 0) to = 0;
    end
    q.push_back('{md, md == 0, ld, fld[1], fld[2], fld[3], sh, s3, s5});
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("mode", int'(mode), e.md);
        chk("run_en", int'(run_en), int'(e.run));
        chk("load", int'(load), int'(e.ld));
        chk("edit_h", int'(edit_h), e.h);
        chk("edit_m", int'(edit_m), e.m);
        chk("edit_s", int'(edit_s), e.s);
        chk("sec_half", int'(sec_half), int'(e.sh));
        chk("sec_3", int'(sec_3), int'(e.s3));
        chk("sec_5", int'(sec_5), int'(e.s5));
      end
    end
  end
  initial begin
    bit [4:0] c;
    step(0, 0, 1);
    step(0, 0, 1);
    run_req = 1;
    repeat (60) step(0, 0, 0);
    run_req = 0;
    repeat (3) step(0, 0, 0);
    nh = 12; nm = 34; ns = 56;
    step(C3S, 0, 0);
    repeat (12) step(C1, 0, 0);
    step(C2, 0, 0);
    step(C3, 0, 0);
    repeat (26) step(C1, 0, 0);
    step(C2, 0, 0);
    step(C3, 0, 0);
    step(C3, 0, 0);
    repeat (3) step(0, 0, 0);
    step(C3S, 0, 0);
    step(C3, 0, 0);
    step(C3, 0, 0);
    step(C1, 0, 0);
    step(C5S, 0, 0);
    step(0, 0, 0);
    step(C1, 0, 0);
    step(C2, 0, 0);
    step(C3S, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(C3S, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(C1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(C3S, 0, 0);
    step(C3 | C5S, 0, 0);
    step(0, 0, 0);
    step(C3S, 0, 0);
    step(C3, 0, 0);
    step(C1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    repeat (3000) begin
      for (int i = 0; i < 5; i++) c[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) run_req = ~run_req;
      if ($urandom_range(0, 15) == 0) begin
        nh = $urandom_range(0, 23); nm = $urandom_range(0, 59); ns = $urandom_range(0, 59);
      end
      step(c, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end
    repeat (3) @(posedge clock);
    #2;
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
